intdiv_otfc: RTL and testbench

//  - On-the-fly converter: turns the divider's SD2 quotient digit stream (MSB first, one digit/cycle) into a
//    two's-complement quotient. No carry-propagate pass over the digits.
//  - Applies the final quotient correction from intdiv_adj (padj/seladj), then presents one registered result.
//  - Sits at the output end of the divider datapath: recurrence -> sign/adjust logic -> this block.

---
 rtl/intdiv_otfc_pkg.sv | 8 +
 rtl/intdiv_otfc_if.sv | 15 +
 rtl/intdiv_otfc_step.sv | 17 +
 rtl/intdiv_otfc.sv | 60 ++++++
 tb/tb_intdiv_otfc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/intdiv_otfc_pkg.sv
// intdiv_otfc_pkg: SD2 digit codes and converter FSM states shared by the intdiv_otfc slice
package intdiv_otfc_pkg;
  typedef enum logic [1:0] {IDLE, CONV, ADJ} state_t;
  localparam logic [1:0] ZERO_1 = 2'b00;
  localparam logic [1:0] POS1 = 2'b01;
  localparam logic [1:0] ZERO_2 = 2'b10;
  localparam logic [1:0] NEG1 = 2'b11;
endpackage

// File: rtl/intdiv_otfc_if.sv
// intdiv_otfc_if: digit stream in (start, dig_valid, dig, dig_last, padj, seladj), result out (q_out, q_valid, busy, ovf)
interface intdiv_otfc_if #(parameter int N = 8);
  logic start;
  logic dig_valid;
  logic [1:0] dig;
  logic dig_last;
  logic padj;
  logic seladj;
  logic [N-1:0] q_out;
  logic q_valid;
  logic busy;
  logic ovf;
  modport master(output start, dig_valid, dig, dig_last, padj, seladj, input q_out, q_valid, busy, ovf);
  modport slave(input start, dig_valid, dig, dig_last, padj, seladj, output q_out, q_valid, busy, ovf);
endinterface

// File: rtl/intdiv_otfc_step.sv
// intdiv_otfc_step: one SD2 digit update of the Q/QM pair (q, qm, dig in; q_nxt, qm_nxt out), keeping QM == Q-1
module intdiv_otfc_step
  import intdiv_otfc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] qm,
  input  logic [1:0]   dig,
  output logic [N-1:0] q_nxt,
  output logic [N-1:0] qm_nxt
);
  always_comb begin
    q_nxt = dig == POS1 ? {q[N-2:0], 1'b1} : dig == NEG1 ? {qm[N-2:0], 1'b1} : {q[N-2:0], 1'b0};
    qm_nxt = dig == POS1 ? {q[N-2:0], 1'b0} : dig == NEG1 ? {qm[N-2:0], 1'b0} : {qm[N-2:0], 1'b1};
  end
endmodule

// File: rtl/intdiv_otfc.sv
// intdiv_otfc: on-the-fly SD2-to-two's-complement quotient converter with final adjust; clk, rst_n, s (intdiv_otfc_if.slave)
module intdiv_otfc
  import intdiv_otfc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  intdiv_otfc_if.slave  s
);
  localparam int CW = $clog2(N + 1);
  state_t state;
  logic [N-1:0] q, qm, q_nxt, qm_nxt, q_adj;
  logic [CW-1:0] cnt;
  logic padj_r, seladj_r;
  intdiv_otfc_step #(.N(N)) u_step (
    .q(q),
    .qm(qm),
    .dig(s.dig),
    .q_nxt(q_nxt),
    .qm_nxt(qm_nxt)
  );
  always_comb q_adj = seladj_r ? q : padj_r ? q + N'(1) : qm;
  assign s.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      qm <= '1;
      cnt <= '0;
      padj_r <= 1'b0;
      seladj_r <= 1'b0;
      s.q_out <= '0;
      s.q_valid <= 1'b0;
      s.ovf <= 1'b0;
    end else begin
      s.q_valid <= state == ADJ;
      if (state == ADJ) s.q_out <= q_adj;
      if (s.start) begin
        state <= CONV;
        q <= '0;
        qm <= '1;
        cnt <= '0;
        s.ovf <= 1'b0;
      end else if (state == CONV && s.dig_valid) begin
        q <= q_nxt;
        qm <= qm_nxt;
        cnt <= cnt == CW'(N) ? cnt : cnt + CW'(1);
        if (cnt == CW'(N)) s.ovf <= 1'b1;
        if (s.dig_last) begin
          padj_r <= s.padj;
          seladj_r <= s.seladj;
          state <= ADJ;
        end
      end else if (state == ADJ) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_intdiv_otfc.sv
// tb_intdiv_otfc: randomized self-checking bench for intdiv_otfc against an integer-arithmetic quotient model
module tb_intdiv_otfc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [1:0] digs [16];
  intdiv_otfc_if #(.N(8)) bus ();
  intdiv_otfc #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.q_valid) pulses++;
  function automatic logic [7:0] model(input int n, input bit sa, input bit pa);
    int v = 0;
    for (int i = 0; i < n; i++) v = v * 2 + (digs[i] == 2'b01 ? 1 : digs[i] == 2'b11 ? -1 : 0);
    v += sa ? 0 : (pa ? 1 : -1);
    return 8'(v);
  endfunction
  task automatic load(input logic [31:0] p, input int n);
    for (int i = 0; i < n; i++) digs[i] = p[2*(n-1-i) +: 2];
  endtask
  task automatic do_run(input int n, input int gap, input bit sa, input bit pa, input bit junk,
                        output logic v_early, output logic v, output logic [7:0] qo,
                        output logic ovf_o, output logic idle_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.dig_valid = junk; bus.dig = 2'b11; bus.dig_last = junk;
    @(negedge clk);
    bus.start = 1'b0; bus.dig_valid = 1'b0; bus.dig_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.dig_valid = 1'b1; bus.dig = digs[i]; bus.dig_last = (i == n - 1); bus.padj = pa; bus.seladj = sa;
      @(negedge clk);
      bus.dig_valid = 1'b0; bus.dig_last = 1'b0; bus.padj = ~pa; bus.seladj = ~sa;
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
    v_early = bus.q_valid;
    @(negedge clk);
    v = bus.q_valid; qo = bus.q_out; ovf_o = bus.ovf;
    @(negedge clk);
    idle_bad = bus.busy | bus.q_valid;
  endtask
  task automatic test_reset();
    n_chk++; if (bus.q_out !== 8'h00) begin n_fail++; $display("FAIL reset_q_out got %h want 00", bus.q_out); end
    n_chk++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid got %b want 0", bus.q_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
  endtask
  task automatic test_basic();
    logic ve, v, o, ib; logic [7:0] q;
    load(32'h0000_0011, 8);
    do_run(8, 0, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (ve !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", ve); end
    n_chk++; if (v !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", v); end
    n_chk++; if (q !== 8'h05) begin n_fail++; $display("FAIL basic_q got %h want 05", q); end
    n_chk++; if (ib !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got %b want 0", ib); end
  endtask
  task automatic test_adjust();
    logic ve, v, o, ib; logic [7:0] q;
    logic [7:0] want [3] = '{8'h03, 8'h02, 8'h04};
    for (int k = 0; k < 3; k++) begin
      load(32'h0000_0013, 8);
      do_run(8, 0, k == 0, k == 2, 1'b0, ve, v, q, o, ib);
      n_chk++; if (v !== 1'b1 || q !== want[k]) begin n_fail++; $display("FAIL adjust%0d got v=%b q=%h want v=1 q=%h", k, v, q, want[k]); end
      n_chk++; if (q !== model(8, k == 0, k == 2)) begin n_fail++; $display("FAIL adjust_model%0d got %h want %h", k, q, model(8, k == 0, k == 2)); end
    end
  endtask
  task automatic test_edges();
    logic ve, v, o, ib; logic [7:0] q;
    load(32'h0000_C000, 8);
    do_run(8, 0, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (q !== 8'h80) begin n_fail++; $display("FAIL edge_min got %h want 80", q); end
    load(32'h0000_0003, 8);
    do_run(8, 0, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL edge_m1 got %h want ff", q); end
    do_run(8, 0, 1'b0, 1'b1, 1'b0, ve, v, q, o, ib);
    n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL edge_wrap got %h want 00", q); end
  endtask
  task automatic test_zero2_gaps();
    logic ve, v, o, ib; logic [7:0] q;
    load(32'h0000_8899, 8);
    do_run(8, 0, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (q !== 8'h05) begin n_fail++; $display("FAIL zero2 got %h want 05", q); end
    load(32'h0000_0011, 8);
    do_run(8, 3, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (v !== 1'b1 || q !== 8'h05) begin n_fail++; $display("FAIL gaps got v=%b q=%h want v=1 q=05", v, q); end
  endtask
  task automatic test_ovf();
    logic ve, v, o, ib; logic [7:0] q;
    load(32'h0001_0011, 9);
    do_run(9, 0, 1'b1, 1'b0, 1'b0, ve, v, q, o, ib);
    n_chk++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", o); end
    n_chk++; if (q !== model(9, 1'b1, 1'b0)) begin n_fail++; $display("FAIL ovf_q got %h want %h", q, model(9, 1'b1, 1'b0)); end
    n_chk++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.ovf); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.ovf); end
  endtask
  task automatic test_abort();
    logic ve, v, o, ib; logic [7:0] q; int p0;
    load(32'h0000_00FF, 4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dig_valid = 1'b1; bus.dig = digs[i]; bus.dig_last = 1'b0;
      @(negedge clk);
    end
    bus.dig_valid = 1'b0;
    p0 = pulses;
    load(32'h0000_0011, 8);
    do_run(8, 0, 1'b1, 1'b0, 1'b1, ve, v, q, o, ib);
    n_chk++; if (q !== 8'h05 || pulses - p0 != 1) begin n_fail++; $display("FAIL abort got q=%h pulses=%0d want q=05 pulses=1", q, pulses - p0); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dig_valid = 1'b1; bus.dig = 2'b01; bus.dig_last = 1'b0;
      @(negedge clk);
    end
    bus.dig_valid = 1'b1; bus.dig_last = 1'b1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.q_out !== 8'h00 || bus.busy !== 1'b0 || bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL midreset got q=%h busy=%b v=%b want 00 0 0", bus.q_out, bus.busy, bus.q_valid); end
    p0 = pulses;
    @(negedge clk);
    bus.dig_valid = 1'b0; bus.dig_last = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (pulses != p0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet got pulses=%0d busy=%b want 0 0", pulses - p0, bus.busy); end
  endtask
  task automatic test_back_to_back();
    load(32'h0000_0011, 8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.dig_valid = 1'b1; bus.dig = digs[i]; bus.dig_last = (i == 7); bus.seladj = 1'b1; bus.padj = 1'b0;
      @(negedge clk);
    end
    bus.dig_valid = 1'b0; bus.dig_last = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++; if (bus.q_valid !== 1'b1 || bus.q_out !== 8'h05 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first got v=%b q=%h busy=%b want 1 05 1", bus.q_valid, bus.q_out, bus.busy); end
    load(32'h0000_0013, 8);
    for (int i = 0; i < 8; i++) begin
      bus.dig_valid = 1'b1; bus.dig = digs[i]; bus.dig_last = (i == 7);
      @(negedge clk);
    end
    bus.dig_valid = 1'b0; bus.dig_last = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.q_valid !== 1'b1 || bus.q_out !== 8'h03) begin n_fail++; $display("FAIL b2b_second got v=%b q=%h want 1 03", bus.q_valid, bus.q_out); end
  endtask
  task automatic test_random();
    logic ve, v, o, ib; logic [7:0] q, exp_q; int n; bit sa, pa;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 10);
      sa = 1'($urandom_range(0, 1)); pa = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) digs[i] = 2'($urandom_range(0, 3));
      exp_q = model(n, sa, pa);
      do_run(n, $urandom_range(0, 2), sa, pa, 1'($urandom_range(0, 1)), ve, v, q, o, ib);
      n_chk++; if (ve !== 1'b0 || v !== 1'b1 || q !== exp_q || ib !== 1'b0) begin n_fail++; $display("FAIL rand%0d got ve=%b v=%b q=%h idle_bad=%b want 0 1 %h 0", t, ve, v, q, ib, exp_q); end
      n_chk++; if (o !== (n > 8)) begin n_fail++; $display("FAIL rand_ovf%0d got %b want %b", t, o, n > 8); end
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.dig_valid = 1'b0; bus.dig = 2'b00; bus.dig_last = 1'b0; bus.padj = 1'b0; bus.seladj = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_adjust();
    test_edges();
    test_zero2_gaps();
    test_ovf();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
